// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures high time and frame period of an incoming servo
// stream, classifies the pulse into a position code and flags bad frames / loss of signal.
module servo_pwm_decoder #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned PULSE_MIN  = 100_000,
    parameter int unsigned PULSE_MAX  = 200_000,
    parameter int unsigned PULSE_TOL  = 10_000,
    parameter int unsigned PERIOD_MIN = 1_500_000,
    parameter int unsigned PERIOD_MAX = 2_500_000,
    parameter int unsigned TIMEOUT    = 3_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [31:0] pulse_width,
    output logic [31:0] period,
    output logic [1:0]  position,
    output logic        sample_valid,
    output logic        range_error,
    output logic        signal_lost
);

    localparam logic [1:0] WAIT_RISE = 2'd0;
    localparam logic [1:0] HIGH      = 2'd1;
    localparam logic [1:0] LOW       = 2'd2;

    if (CLOCK_FREQ == 0 || PULSE_MAX <= PULSE_MIN || PERIOD_MAX < PERIOD_MIN) begin : g_bad_params
        $error("servo_pwm_decoder: inconsistent parameters");
    end

    logic        sync_meta;
    logic        sync;
    logic        prev;
    logic        rise;
    logic        fall;
    logic [1:0]  settle;
    logic        armed;
    logic [1:0]  state;
    logic [31:0] cnt;
    logic [31:0] cnt_inc;
    logic [31:0] hi_len;
    logic        period_ok;
    logic        width_ok;
    logic        frame_ok;
    logic        timed_out;
    logic [1:0]  position_next;
    logic [32:0] hi_wide;

    // Bounds are evaluated in 33 bits so that MIN-TOL / MAX+TOL can never wrap.
    always_comb begin
        cnt_inc       = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
        timed_out     = (cnt >= 32'(TIMEOUT));
        hi_wide       = {1'b0, hi_len};
        period_ok     = (cnt >= 32'(PERIOD_MIN)) && (cnt <= 32'(PERIOD_MAX));
        width_ok      = ((hi_wide + 33'(PULSE_TOL)) >= 33'(PULSE_MIN)) &&
                        (hi_wide <= (33'(PULSE_MAX) + 33'(PULSE_TOL)));
        frame_ok      = period_ok && width_ok;
        position_next = 2'd1;
        if (hi_wide <= (33'(PULSE_MIN) + 33'(PULSE_TOL))) begin
            position_next = 2'd0;
        end else if ((hi_wide + 33'(PULSE_TOL)) >= 33'(PULSE_MAX)) begin
            position_next = 2'd2;
        end
    end

    // Edges are registered; 'armed' only comes up once the synchroniser has
    // settled and seen a low level, so a pulse already in progress out of reset is skipped.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta    <= 1'b0;
            sync         <= 1'b0;
            prev         <= 1'b0;
            rise         <= 1'b0;
            fall         <= 1'b0;
            settle       <= 2'd0;
            armed        <= 1'b0;
            state        <= WAIT_RISE;
            cnt          <= 32'd0;
            hi_len       <= 32'd0;
            pulse_width  <= 32'd0;
            period       <= 32'd0;
            position     <= 2'd0;
            sample_valid <= 1'b0;
            range_error  <= 1'b0;
            signal_lost  <= 1'b0;
        end else begin
            sync_meta    <= pwm_in;
            sync         <= sync_meta;
            prev         <= sync;
            rise         <= sync & ~prev;
            fall         <= ~sync & prev;
            sample_valid <= 1'b0;
            range_error  <= 1'b0;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            if (settle == 2'd2 && !sync) begin
                armed <= 1'b1;
            end

            case (state)
                WAIT_RISE: begin
                    cnt <= 32'd0;
                    if (rise && armed) begin
                        cnt   <= 32'd1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hi_len <= cnt;
                        cnt    <= cnt_inc;
                        state  <= LOW;
                    end else if (timed_out) begin
                        cnt         <= 32'd0;
                        state       <= WAIT_RISE;
                        signal_lost <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        cnt   <= 32'd1;
                        state <= HIGH;
                        if (frame_ok) begin
                            pulse_width  <= hi_len;
                            period       <= cnt;
                            position     <= position_next;
                            sample_valid <= 1'b1;
                            signal_lost  <= 1'b0;
                        end else begin
                            range_error <= 1'b1;
                        end
                    end else if (timed_out) begin
                        cnt         <= 32'd0;
                        state       <= WAIT_RISE;
                        signal_lost <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    cnt   <= 32'd0;
                    state <= WAIT_RISE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed testbench for servo_pwm_decoder using scaled-down timing parameters;
// a monitor logs every strobe and scenarios compare against hand-computed values.
module tb_servo_pwm_decoder;

    logic        clk;
    logic        reset;
    logic        pwm_in;
    logic [31:0] pulse_width;
    logic [31:0] period;
    logic [1:0]  position;
    logic        sample_valid;
    logic        range_error;
    logic        signal_lost;

    int checks = 0;
    int errors = 0;

    int          sv_total = 0;
    int          re_total = 0;
    int          both_total = 0;
    logic [31:0] log_pw   [0:63];
    logic [31:0] log_per  [0:63];
    logic [1:0]  log_pos  [0:63];
    logic        log_lost [0:63];

    servo_pwm_decoder #(
        .CLOCK_FREQ(100_000_000),
        .PULSE_MIN (100),
        .PULSE_MAX (200),
        .PULSE_TOL (10),
        .PERIOD_MIN(1500),
        .PERIOD_MAX(2500),
        .TIMEOUT   (3000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .pulse_width (pulse_width),
        .period      (period),
        .position    (position),
        .sample_valid(sample_valid),
        .range_error (range_error),
        .signal_lost (signal_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes last one cycle, so one negedge sample per strobe is enough.
    always @(negedge clk) begin
        if (sample_valid) begin
            if (sv_total < 64) begin
                log_pw[sv_total]   <= pulse_width;
                log_per[sv_total]  <= period;
                log_pos[sv_total]  <= position;
                log_lost[sv_total] <= signal_lost;
            end
            sv_total <= sv_total + 1;
        end
        if (range_error) re_total <= re_total + 1;
        if (sample_valid && range_error) both_total <= both_total + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one frame from a negedge; lat = negedges from the rise to the first sample_valid (0 if none).
    task automatic applyStimulus(input int hi, input int lo, output int lat);
        int k;
        lat = 0;
        k = 0;
        pwm_in = 1'b1;
        repeat (hi) begin
            @(negedge clk);
            k++;
            if (sample_valid && lat == 0) lat = k;
        end
        pwm_in = 1'b0;
        repeat (lo) begin
            @(negedge clk);
            k++;
            if (sample_valid && lat == 0) lat = k;
        end
    endtask

    task automatic doReset(input logic level);
        pwm_in = level;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        int sv_base;
        int re_base;

        reset  = 1'b1;
        pwm_in = 1'b0;
        doReset(1'b0);
        checkOutput("reset_pulse_width", pulse_width, 32'd0);
        checkOutput("reset_period", period, 32'd0);
        checkOutput("reset_position", 32'(position), 32'd0);
        checkOutput("reset_strobes", {30'd0, sample_valid, range_error}, 32'd0);
        checkOutput("reset_signal_lost", 32'(signal_lost), 32'd0);
        repeat (5) @(negedge clk);

        // Scenario 1: three 1 ms frames.
        sv_base = sv_total;
        re_base = re_total;
        repeat (3) applyStimulus(100, 1900, lat);
        applyStimulus(20, 20, lat);
        checkOutput("s1_sv_count", 32'(sv_total - sv_base), 32'd3);
        checkOutput("s1_re_count", 32'(re_total - re_base), 32'd0);
        checkOutput("s1_pulse_width", pulse_width, 32'd100);
        checkOutput("s1_period", period, 32'd2000);
        checkOutput("s1_position", 32'(position), 32'd0);

        // Scenario 2: far end then intermediate, with latency.
        doReset(1'b0);
        repeat (5) @(negedge clk);
        sv_base = sv_total;
        applyStimulus(200, 1800, lat);
        applyStimulus(150, 1850, lat);
        checkOutput("s2_latency_first", 32'(lat), 32'd4);
        checkOutput("s2_first_pw", log_pw[sv_base], 32'd200);
        checkOutput("s2_first_pos", 32'(log_pos[sv_base]), 32'd2);
        applyStimulus(20, 20, lat);
        checkOutput("s2_latency_second", 32'(lat), 32'd4);
        checkOutput("s2_pulse_width", pulse_width, 32'd150);
        checkOutput("s2_period", period, 32'd2000);
        checkOutput("s2_position", 32'(position), 32'd1);

        // Scenario 3: short pulse then short period, both rejected.
        doReset(1'b0);
        repeat (5) @(negedge clk);
        applyStimulus(100, 1900, lat);
        sv_base = sv_total;
        re_base = re_total;
        applyStimulus(50, 1950, lat);
        applyStimulus(100, 1000, lat);
        applyStimulus(20, 20, lat);
        checkOutput("s3_sv_count", 32'(sv_total - sv_base), 32'd1);
        checkOutput("s3_re_count", 32'(re_total - re_base), 32'd2);
        checkOutput("s3_no_valid_late", 32'(lat), 32'd0);
        checkOutput("s3_pulse_width_kept", pulse_width, 32'd100);
        checkOutput("s3_period_kept", period, 32'd2000);
        checkOutput("s3_position_kept", 32'(position), 32'd0);

        // Scenario 4: loss of signal, then recovery.
        doReset(1'b0);
        repeat (5) @(negedge clk);
        sv_base = sv_total;
        re_base = re_total;
        applyStimulus(100, 1900, lat);
        applyStimulus(100, 3500, lat);
        checkOutput("s4_signal_lost_set", 32'(signal_lost), 32'd1);
        applyStimulus(100, 1900, lat);
        checkOutput("s4_lost_held_waiting", 32'(signal_lost), 32'd1);
        applyStimulus(100, 1900, lat);
        applyStimulus(20, 20, lat);
        checkOutput("s4_sv_count", 32'(sv_total - sv_base), 32'd3);
        checkOutput("s4_re_count", 32'(re_total - re_base), 32'd0);
        checkOutput("s4_lost_at_first_valid", 32'(log_lost[sv_base + 1]), 32'd0);
        checkOutput("s4_signal_lost_clear", 32'(signal_lost), 32'd0);

        // Scenario 5: input already high when reset releases.
        doReset(1'b1);
        sv_base = sv_total;
        re_base = re_total;
        applyStimulus(80, 1880, lat);
        applyStimulus(120, 1880, lat);
        applyStimulus(120, 1880, lat);
        applyStimulus(20, 20, lat);
        checkOutput("s5_re_count", 32'(re_total - re_base), 32'd0);
        checkOutput("s5_sv_count", 32'(sv_total - sv_base), 32'd2);
        checkOutput("s5_first_pw", log_pw[sv_base], 32'd120);
        checkOutput("s5_first_period", log_per[sv_base], 32'd2000);
        checkOutput("s5_first_pos", 32'(log_pos[sv_base]), 32'd1);

        // Scenario 6: one-cycle reset in the middle of a high pulse.
        doReset(1'b0);
        repeat (5) @(negedge clk);
        applyStimulus(100, 1900, lat);
        pwm_in = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("s6_pre_reset_pw", pulse_width, 32'd100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("s6_reset_pulse_width", pulse_width, 32'd0);
        checkOutput("s6_reset_period", period, 32'd0);
        checkOutput("s6_reset_position", 32'(position), 32'd0);
        checkOutput("s6_reset_strobes", {30'd0, sample_valid, range_error}, 32'd0);
        sv_base = sv_total;
        re_base = re_total;
        repeat (50) @(negedge clk);
        pwm_in = 1'b0;
        repeat (1900) @(negedge clk);
        checkOutput("s6_no_valid_after_partial", 32'(sv_total - sv_base), 32'd0);
        applyStimulus(100, 1900, lat);
        applyStimulus(20, 20, lat);
        checkOutput("s6_sv_count", 32'(sv_total - sv_base), 32'd1);
        checkOutput("s6_re_count", 32'(re_total - re_base), 32'd0);
        checkOutput("s6_first_pw", log_pw[sv_base], 32'd100);
        checkOutput("s6_first_period", log_per[sv_base], 32'd2000);

        checkOutput("strobes_exclusive", 32'(both_total), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Receive-side counterpart of the servo PWM generator: measures an incoming servo-style PWM stream and decodes it.
- Reports pulse width, frame period and a 2-bit position code per frame; flags out-of-range frames and loss of signal.
- Used to loop back the sorter's own servo drive for self-test, and to read an external RC/servo command line.

Parameters:
- CLOCK_FREQ, 100_000_000, clock rate in Hz; informational only, no logic depends on it.
- PULSE_MIN, 100_000, nominal 0-position pulse width in cycles (1 ms).
- PULSE_MAX, 200_000, nominal 180-position pulse width in cycles (2 ms).
- PULSE_TOL, 10_000, tolerance band in cycles around PULSE_MIN and PULSE_MAX.
- PERIOD_MIN, 1_500_000, shortest accepted frame in cycles (15 ms).
- PERIOD_MAX, 2_500_000, longest accepted frame in cycles (25 ms).
- TIMEOUT, 3_000_000, cycles without an expected edge before signal is declared lost.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pwm_in  in  1  asynchronous PWM input
- pulse_width  out  32  high time of last completed frame, in cycles
- period  out  32  rising-to-rising length of last completed frame, in cycles
- position  out  2  0 = near PULSE_MIN, 1 = intermediate, 2 = near PULSE_MAX; 3 is never produced
- sample_valid  out  1  one-cycle strobe: frame accepted and outputs updated
- range_error  out  1  one-cycle strobe: frame completed but rejected
- signal_lost  out  1  level, set on timeout

Behaviour:
- Input path: 2-flop synchroniser followed by a previous-value register.
  - Rise = sync & ~prev; fall = ~sync & prev.
  - Edge detect lags pwm_in by 3 cycles. Widths are measured between detected edges, so the lag does not affect them.
- Single 32-bit counter cnt. cnt saturates at 2^32-1 and never wraps.
- State WAIT_RISE (reset state):
  - cnt is held at 0. If pwm_in is already high out of reset, that partial pulse is ignored.
  - On rise: cnt <= 1, go to HIGH.
- State HIGH:
  - cnt increments each cycle.
  - On fall: hi_len <= cnt, cnt increments, go to LOW.
  - If cnt reaches TIMEOUT: go to WAIT_RISE, signal_lost <= 1.
- State LOW:
  - cnt increments each cycle.
  - On rise: the frame completes (see Frame evaluation). cnt <= 1, stay in the frame loop and go to HIGH.
  - If cnt reaches TIMEOUT: go to WAIT_RISE, signal_lost <= 1.
  - A constant-low or constant-high input therefore always ends in WAIT_RISE with signal_lost = 1.
- Frame evaluation, on the rise that ends LOW, with per = cnt:
  - Accept the frame if PERIOD_MIN <= per <= PERIOD_MAX and (PULSE_MIN - PULSE_TOL) <= hi_len <= (PULSE_MAX + PULSE_TOL).
  - Accepted, on the next cycle: pulse_width <= hi_len, period <= per, position updated, sample_valid = 1 for one cycle, signal_lost <= 0.
  - Rejected: range_error = 1 for one cycle. pulse_width, period, position and signal_lost keep their values.
- Position rule:
  - 0 if hi_len <= PULSE_MIN + PULSE_TOL.
  - 2 if hi_len >= PULSE_MAX - PULSE_TOL.
  - 1 otherwise.
  - Comparisons are unsigned, done in 33 bits so bound arithmetic cannot wrap.
- sample_valid and range_error are never both high in the same cycle.
- Rise and fall of the synchronised signal cannot both occur in one cycle, so no simultaneous-edge case exists.
- Reset, including mid-frame, forces on the next edge:
  - state = WAIT_RISE, cnt = 0;
  - pulse_width = 0, period = 0, position = 0;
  - sample_valid = 0, range_error = 0, signal_lost = 0;
  - synchroniser and previous-value registers = 0.
- Latency: sample_valid asserts 4 cycles after the pwm_in rising edge that closes the frame.

Test Plan:
Bench parameters for all scenarios: PULSE_MIN=100, PULSE_MAX=200, PULSE_TOL=10, PERIOD_MIN=1500, PERIOD_MAX=2500, TIMEOUT=3000.
1. Frames of 100 high / 1900 low, repeated 3 times -> from the second rise on: sample_valid per frame, pulse_width=100, period=2000, position=0, range_error never.
2. Frames of 200/1800 then 150/1850 -> position=2 with pulse_width=200, then position=1 with pulse_width=150; sample_valid 4 cycles after each closing rise.
3. Frame of 50/1950, then 100/1000 -> two range_error strobes; pulse_width, period and position keep their prior values; no sample_valid.
4. pwm_in held low for 3500 cycles after a valid frame -> signal_lost=1 and state WAIT_RISE; next two good frames -> signal_lost=0 at the first sample_valid.
5. pwm_in high at reset release for 80 cycles, then normal 120/1880 frames -> partial pulse ignored; first sample_valid reports pulse_width=120, period=2000, position=1.
6. reset asserted for 1 cycle mid-HIGH of a valid stream -> all outputs zero next cycle; first sample_valid only after one full fresh frame.
